mmio_gpio: RTL and testbench

Parametrised memory-mapped GPIO unit replacing the fixed 24-bit switch and LED peripherals on the CPU's IO path. It synchronises and debounces a configurable number of switch inputs, holds a configurable-width LED register, and latches sticky rising-edge flags per switch with a maskable pending output. It sits behind the memory/IO address decoder and is accessed with word loads and stores.

---
 rtl/gpio_pkg.sv | 11 +
 rtl/gpio_debounce.sv | 69 ++++++
 rtl/mmio_gpio.sv | 114 +++++++++++
 tb/tb_mmio_gpio.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared constants for the memory-mapped GPIO block: register offsets and bus width.
package gpio_pkg;

  localparam int GPIO_DW = 32;

  localparam logic [3:0] GPIO_SW_OFF      = 4'h0;
  localparam logic [3:0] GPIO_LED_OFF     = 4'h4;
  localparam logic [3:0] GPIO_EDGE_OFF    = 4'h8;
  localparam logic [3:0] GPIO_EDGE_EN_OFF = 4'hC;

endpackage

// File: rtl/gpio_debounce.sv
// One switch bit: two-flop synchroniser, optional debounce counter (GPIO_DEBOUNCE_EN),
// and a one-cycle rising-edge pulse on the accepted (stable) value.
module gpio_debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_sw,
  output logic o_stable,
  output logic o_rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic w_stable;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_sw;
      r_sync2 <= r_sync1;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] TC = CW'(DB_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_stable;

  // Any cycle where the synced value agrees with stable restarts the qualification window.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (r_sync2 == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == TC) begin
      r_stable <= r_sync2;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign w_stable = r_stable;
`else
  logic w_unused_db;

  assign w_unused_db = (DB_CYCLES > 1);
  assign w_stable    = r_sync2;
`endif

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_stable;
    end
  end

  assign o_stable = w_stable;
  assign o_rise   = w_stable & ~r_prev;

endmodule

// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO: debounced switches, LED register, sticky rising-edge flags with mask.
// Debounce counters are built only when GPIO_DEBOUNCE_EN is defined (see gpio_debounce).
module mmio_gpio
  import gpio_pkg::*;
#(
  parameter int SW_WIDTH  = 24,
  parameter int LED_WIDTH = 24,
  parameter int DB_CYCLES = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_cs,
  input  logic                 io_read,
  input  logic                 io_write,
  input  logic [3:0]           addr,
  input  logic [GPIO_DW-1:0]   wdata,
  output logic [GPIO_DW-1:0]   rdata,
  input  logic [SW_WIDTH-1:0]  switch_i,
  output logic [LED_WIDTH-1:0] led_o,
  output logic                 edge_pending
);

  logic [3:0]           w_off;
  logic                 w_wr;
  logic                 w_rd;
  logic                 w_wr_led;
  logic                 w_wr_edge;
  logic                 w_wr_edge_en;
  logic [SW_WIDTH-1:0]  w_stable;
  logic [SW_WIDTH-1:0]  w_rise;
  logic [SW_WIDTH-1:0]  w_clr;
  logic [GPIO_DW-1:0]   w_sw_ext;
  logic [GPIO_DW-1:0]   w_led_ext;
  logic [GPIO_DW-1:0]   w_edge_ext;
  logic [GPIO_DW-1:0]   w_edge_en_ext;
  logic                 w_unused_bits;

  logic [LED_WIDTH-1:0] r_led;
  logic [SW_WIDTH-1:0]  r_edge;
  logic [SW_WIDTH-1:0]  r_edge_en;

  assign w_off         = {addr[3:2], 2'b00};
  assign w_wr          = io_cs & io_write;
  assign w_rd          = io_cs & io_read;
  assign w_wr_led      = w_wr && (w_off == GPIO_LED_OFF);
  assign w_wr_edge     = w_wr && (w_off == GPIO_EDGE_OFF);
  assign w_wr_edge_en  = w_wr && (w_off == GPIO_EDGE_EN_OFF);
  assign w_unused_bits = ^{addr[1:0], wdata};

  for (genvar g = 0; g < SW_WIDTH; g++) begin : g_sw
    gpio_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .i_clock (clock),
      .i_reset (reset),
      .i_sw    (switch_i[g]),
      .o_stable(w_stable[g]),
      .o_rise  (w_rise[g])
    );
  end

  assign w_clr = w_wr_edge ? wdata[SW_WIDTH-1:0] : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_led     <= '0;
      r_edge_en <= '0;
    end else begin
      if (w_wr_led) begin
        r_led <= wdata[LED_WIDTH-1:0];
      end
      if (w_wr_edge_en) begin
        r_edge_en <= wdata[SW_WIDTH-1:0];
      end
    end
  end

  // A new rising edge is ORed in after the clear, so it survives a same-cycle W1C.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_edge <= '0;
    end else begin
      r_edge <= (r_edge & ~w_clr) | w_rise;
    end
  end

  always_comb begin
    w_sw_ext      = '0;
    w_led_ext     = '0;
    w_edge_ext    = '0;
    w_edge_en_ext = '0;
    w_sw_ext[SW_WIDTH-1:0]       = w_stable;
    w_led_ext[LED_WIDTH-1:0]     = r_led;
    w_edge_ext[SW_WIDTH-1:0]     = r_edge;
    w_edge_en_ext[SW_WIDTH-1:0]  = r_edge_en;
  end

  always_comb begin
    rdata = '0;
    if (w_rd) begin
      case (w_off)
        GPIO_SW_OFF:      rdata = w_sw_ext;
        GPIO_LED_OFF:     rdata = w_led_ext;
        GPIO_EDGE_OFF:    rdata = w_edge_ext;
        GPIO_EDGE_EN_OFF: rdata = w_edge_en_ext;
        default:          rdata = '0;
      endcase
    end
  end

  assign led_o        = r_led;
  assign edge_pending = |(r_edge & r_edge_en);

endmodule

// File: tb/tb_mmio_gpio.sv
// Self-checking bench for mmio_gpio: directed scenarios plus randomized traffic
// checked against a sample-history reference model.
module tb_mmio_gpio;

  localparam int SW = 24;
  localparam int LW = 16;
  localparam int DB = 4;
`ifdef GPIO_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif
  localparam int LAT = DB_EN ? 2 + DB : 2;

  logic          clock    = 1'b0;
  logic          reset    = 1'b0;
  logic          io_cs    = 1'b0;
  logic          io_read  = 1'b0;
  logic          io_write = 1'b0;
  logic [3:0]    addr     = '0;
  logic [31:0]   wdata    = '0;
  logic [31:0]   rdata;
  logic [SW-1:0] switch_i = '0;
  logic [LW-1:0] led_o;
  logic          edge_pending;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mmio_gpio #(
    .SW_WIDTH (SW),
    .LED_WIDTH(LW),
    .DB_CYCLES(DB)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .io_cs       (io_cs),
    .io_read     (io_read),
    .io_write    (io_write),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .switch_i    (switch_i),
    .led_o       (led_o),
    .edge_pending(edge_pending)
  );

  // Reference model: a switch bit is accepted once the last DB synchronised samples
  // all disagree with the accepted value (DB=1 path without debounce uses raw(n-1)).
  logic [SW-1:0] hist[$];
  logic [SW-1:0] m_stable = '0;
  logic [SW-1:0] m_prev   = '0;
  logic [SW-1:0] m_edge   = '0;
  logic [SW-1:0] m_en     = '0;
  logic [LW-1:0] m_led    = '0;
  logic [SW-1:0] m_clr;
  logic [SW-1:0] m_next;
  logic [SW-1:0] m_h;
  logic          m_run;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist.delete();
      m_stable = '0;
      m_prev   = '0;
      m_edge   = '0;
      m_en     = '0;
      m_led    = '0;
    end else begin
      m_clr = '0;
      if (io_cs && io_write) begin
        case (addr[3:2])
          2'd1:    m_led = wdata[LW-1:0];
          2'd2:    m_clr = wdata[SW-1:0];
          2'd3:    m_en  = wdata[SW-1:0];
          default: ;
        endcase
      end
      m_edge = (m_edge & ~m_clr) | (m_stable & ~m_prev);
      m_prev = m_stable;
      hist.push_front(switch_i);
      if (hist.size() > DB + 2) void'(hist.pop_back());
      m_next = m_stable;
      if (DB_EN) begin
        if (hist.size() == DB + 2) begin
          for (int b = 0; b < SW; b++) begin
            m_run = 1'b1;
            for (int k = 0; k < DB; k++) begin
              m_h = hist[2 + k];
              if (m_h[b] == m_stable[b]) m_run = 1'b0;
            end
            if (m_run) m_next[b] = ~m_stable[b];
          end
        end
      end else if (hist.size() >= 2) begin
        m_next = hist[1];
      end
      m_stable = m_next;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [3:0] a);
    case (a[3:2])
      2'd0:    return 32'(m_stable);
      2'd1:    return 32'(m_led);
      2'd2:    return 32'(m_edge);
      default: return 32'(m_en);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    io_cs = 1'b1; io_read = 1'b1; addr = a;
    #1;
    d = rdata;
    io_cs = 1'b0; io_read = 1'b0; addr = '0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    io_cs = 1'b1; io_write = 1'b1; addr = a; wdata = d;
    @(posedge clock);
    @(negedge clock);
    io_cs = 1'b0; io_write = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_led"}, 32'(led_o), 32'(m_led));
    check({tag, "_pend"}, 32'(edge_pending), 32'(|(m_edge & m_en)));
  endtask

  logic [31:0] d;

  initial begin
    repeat (3) @(negedge clock);
    check("rst_led", 32'(led_o), 32'h0);
    check("rst_pend", 32'(edge_pending), 32'h0);
    rd(4'h0, d); check("rst_sw", d, 32'h0);
    reset = 1'b1;
    @(negedge clock);

    wr(4'h4, 32'hFFFF_A5C3);
    check("led_o", 32'(led_o), 32'h0000_A5C3);
    rd(4'h4, d); check("led_rd", d, 32'h0000_A5C3);

    switch_i[0] = 1'b1;
    tick(LAT - 1);
    rd(4'h0, d); check("sw_early", d, 32'h0);
    tick(1);
    rd(4'h0, d); check("sw_lat", d, 32'h1);
    rd(4'h8, d); check("edge_not_yet", d, 32'h0);
    tick(1);
    rd(4'h8, d); check("edge0", d, 32'h1);

    switch_i[3] = 1'b1;
    tick(3);
    switch_i[3] = 1'b0;
    tick(LAT + 2);
    rd(4'h0, d); check("glitch_sw", d, 32'h1);
    rd(4'h8, d); check("glitch_edge", d, DB_EN ? 32'h1 : 32'h9);

    wr(4'hC, 32'h1);
    check("pend_set", 32'(edge_pending), 32'h1);
    wr(4'h8, 32'h1);
    rd(4'h8, d); check("w1c", d, DB_EN ? 32'h0 : 32'h8);
    check("pend_clr", 32'(edge_pending), 32'h0);

    switch_i[0] = 1'b0;
    tick(LAT + 2);
    rd(4'h8, d); check("fall_ignored", d, DB_EN ? 32'h0 : 32'h8);
    switch_i[0] = 1'b1;
    tick(LAT);
    wr(4'h8, 32'h1);
    rd(4'h8, d); check("set_wins", d, DB_EN ? 32'h1 : 32'h9);
    check("set_wins_pend", 32'(edge_pending), 32'h1);

    switch_i = 24'h80_0001;
    tick(LAT - 1);
    rd(4'h0, d); check("step_early", d, 32'h0000_0001);
    tick(1);
    rd(4'h0, d); check("step_lat", d, 32'h0080_0001);
    switch_i[5] = 1'b1;
    tick(1);
    switch_i[5] = 1'b0;
    tick(1);
    rd(4'h0, d); check("glitch1", d, DB_EN ? 32'h0080_0001 : 32'h0080_0021);
    tick(3);

    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_led", 32'(led_o), 32'h0);
    check("mid_rst_pend", 32'(edge_pending), 32'h0);
    rd(4'h0, d); check("mid_rst_sw", d, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    tick(LAT + 1);
    rd(4'h8, d); check("rst_fresh_edge", d, 32'h0080_0001);
    rd(4'h4, d); check("rst_led_rd", d, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) switch_i[$urandom_range(0, SW - 1)] ^= 1'b1;
      io_cs    = ($urandom_range(0, 2) != 0);
      io_read  = $urandom_range(0, 1) == 1;
      io_write = ($urandom_range(0, 3) == 0);
      addr     = 4'($urandom_range(0, 15));
      wdata    = $urandom;
      #1;
      check("rnd_rd", rdata, (io_cs && io_read) ? exp_rd(addr) : 32'h0);
      check_outs("rnd");
      @(negedge clock);
    end
    io_cs = 1'b0; io_read = 1'b0; io_write = 1'b0;
    tick(1);
    check_outs("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
